// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the display scheduler: FSM states, decimal
// limits, overflow patterns and the shift-add-3 step used by the BCD converter.
package disp_sched_pkg;

    typedef enum logic [1:0] {IDLE, ARB, CONV, SHOW} state_t;

    localparam int unsigned DEC_LIMIT   = 9999;
    localparam logic [15:0] BCD_SAT     = 16'h9999;
    localparam logic [15:0] BCD_ERR     = 16'hEEEE;
    localparam int unsigned CONV_CYCLES = 16;

    // One double-dabble iteration: correct every digit >= 5, then shift in the next bit.
    function automatic logic [15:0] bcd_step(input logic [15:0] acc, input logic bit_in);
        logic [15:0] adj;
        logic [3:0]  nib;
        adj = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            nib = acc[i*4 +: 4];
            if (nib >= 4'd5) nib = nib + 4'd3;
            adj[i*4 +: 4] = nib;
        end
        return {adj[14:0], bit_in};
    endfunction

endpackage

// File: rtl/disp_scheduler_if.sv
// Request/display bundle between the sources, the scheduler and the display mux.
interface disp_scheduler_if #(
    parameter int NSRC = 4,
    parameter int W    = 16
);
    logic [NSRC-1:0]   req;
    logic [NSRC-1:0]   bcd_mode;
    logic [NSRC*W-1:0] src_value;
    logic [NSRC-1:0]   grant;
    logic [W-1:0]      disp_value;
    logic              disp_valid;
    logic              conv_busy;
    logic              ovf;

    modport slave (
        input  req, bcd_mode, src_value,
        output grant, disp_value, disp_valid, conv_busy, ovf
    );

    modport master (
        output req, bcd_mode, src_value,
        input  grant, disp_value, disp_valid, conv_busy, ovf
    );
endinterface

// File: rtl/disp_scheduler_bin2bcd_seq.sv
// Sequential 16-bit binary to 4-digit BCD converter (shift-add-3), one bit per cycle.
module bin2bcd_seq
    import disp_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        done,
    output logic [15:0] bcd
);
    logic [15:0] sh;
    logic [4:0]  cnt;

    // The first bit is shifted in at load, so the remaining 15 steps finish with
    // done asserted in the 16th cycle after start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bcd <= {15'b0, bin[15]};
                sh  <= {bin[14:0], 1'b0};
                cnt <= 5'(CONV_CYCLES - 1);
            end else if (cnt != 5'd0) begin
                bcd  <= bcd_step(bcd, sh[15]);
                sh   <= {sh[14:0], 1'b0};
                cnt  <= cnt - 5'd1;
                done <= (cnt == 5'd1);
            end
        end
    end
endmodule

// File: rtl/disp_scheduler.sv
// Round-robin owner of the 4-digit display with optional BCD conversion per source.
// DISP_SAT_EN: decimal overflow shows 9999 instead of the EEEE error pattern.
module disp_scheduler
    import disp_sched_pkg::*;
#(
    parameter int NSRC  = 4,
    parameter int DWELL = 50_000_000,
    parameter int W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    disp_scheduler_if.slave    bus
);
    localparam int PW = $clog2(NSRC);
    localparam int DW = $clog2(DWELL);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
`ifdef DISP_SAT_EN
    localparam logic [W-1:0] OVF_PAT = W'(BCD_SAT);
`else
    localparam logic [W-1:0] OVF_PAT = W'(BCD_ERR);
`endif

    state_t          state_q, state_n;
    logic [PW-1:0]   ptr_q;
    logic [DW-1:0]   dwell_q;
    logic [NSRC-1:0] grant_q;
    logic [W-1:0]    disp_q;
    logic [W-1:0]    snap_q;
    logic            valid_q, busy_q, ovf_q;

    logic            win_ok, win_dec, conv_start, conv_done;
    logic [PW-1:0]   win_idx, ptr_nxt, idx;
    logic [W-1:0]    win_val;
    logic [15:0]     conv_bcd;

    // Search starts at the pointer and wraps modulo NSRC, so NSRC need not be a power of two.
    always_comb begin
        win_ok  = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            idx = PW'((32'(ptr_q) + i) % NSRC);
            if (!win_ok && bus.req[idx]) begin
                win_ok  = 1'b1;
                win_idx = idx;
            end
        end
        win_val = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (PW'(i) == win_idx) win_val = bus.src_value[i*W +: W];
        end
        win_dec = bus.bcd_mode[win_idx];
        ptr_nxt = (win_idx == PW'(NSRC - 1)) ? '0 : win_idx + PW'(1);
    end

    always_comb begin
        state_n    = state_q;
        conv_start = 1'b0;
        case (state_q)
            IDLE: if (|bus.req) state_n = ARB;
            ARB: begin
                if (!win_ok) begin
                    state_n = IDLE;
                end else if (win_dec) begin
                    state_n    = CONV;
                    conv_start = 1'b1;
                end else begin
                    state_n = SHOW;
                end
            end
            CONV: if (conv_done) state_n = SHOW;
            SHOW: if (dwell_q == '0) state_n = ARB;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            dwell_q <= '0;
            grant_q <= '0;
            disp_q  <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            busy_q <= (state_n == CONV);
            case (state_q)
                ARB: begin
                    ovf_q <= 1'b0;
                    if (win_ok) begin
                        grant_q <= NSRC'(1) << win_idx;
                        ptr_q   <= ptr_nxt;
                        snap_q  <= win_val;
                        if (!win_dec) begin
                            disp_q  <= win_val;
                            valid_q <= 1'b1;
                            dwell_q <= DWELL_LAST;
                        end
                    end else begin
                        grant_q <= '0;
                        valid_q <= 1'b0;
                    end
                end
                CONV: begin
                    if (conv_done) begin
                        valid_q <= 1'b1;
                        dwell_q <= DWELL_LAST;
                        if (32'(snap_q) > DEC_LIMIT) begin
                            ovf_q  <= 1'b1;
                            disp_q <= OVF_PAT;
                        end else begin
                            disp_q <= W'(conv_bcd);
                        end
                    end
                end
                SHOW: if (dwell_q != '0) dwell_q <= dwell_q - DW'(1);
                default: ;
            endcase
        end
    end

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (16'(win_val)),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign bus.grant      = grant_q;
    assign bus.disp_value = disp_q;
    assign bus.disp_valid = valid_q;
    assign bus.conv_busy  = busy_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_disp_scheduler.sv
// Directed bench for disp_scheduler with a per-grant timeline model and literal spot checks.
module tb_disp_scheduler;
    localparam int NSRC  = 4;
    localparam int DWELL = 8;
    localparam int W     = 16;
`ifdef DISP_SAT_EN
    localparam logic [15:0] OVF_PAT = 16'h9999;
`else
    localparam logic [15:0] OVF_PAT = 16'hEEEE;
`endif

    typedef struct packed {
        logic [3:0]  grant;
        logic [15:0] value;
        logic        valid;
        logic        busy;
        logic        ovf;
        logic        arb;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    disp_scheduler_if #(.NSRC(NSRC), .W(W)) bus ();

    disp_scheduler #(.NSRC(NSRC), .DWELL(DWELL), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: each grant is expanded into its whole cycle-by-cycle timeline when it is won.
    rec_t        cur;
    rec_t        q[$];
    rec_t        r;
    int          mptr;
    bit          arb_now;
    bit          chk_en = 1'b0;
    bit          found;
    int          w;
    int unsigned v;

    function automatic logic [15:0] dec_show(input int unsigned val);
        if (val > 9999) return OVF_PAT;
        return {4'(val / 1000), 4'((val / 100) % 10), 4'((val / 10) % 10), 4'(val % 10)};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            cur     = '0;
            q.delete();
            mptr    = 0;
            arb_now = 1'b0;
            chk_en  = 1'b1;
        end else if (arb_now) begin
            found = 1'b0;
            w     = 0;
            for (int i = 0; i < NSRC; i++) begin
                if (!found && bus.req[(mptr + i) % NSRC]) begin
                    found = 1'b1;
                    w     = (mptr + i) % NSRC;
                end
            end
            if (!found) begin
                cur.grant = '0;
                cur.valid = 1'b0;
                cur.busy  = 1'b0;
                cur.ovf   = 1'b0;
                cur.arb   = 1'b0;
                arb_now   = 1'b0;
            end else begin
                mptr    = (w + 1) % NSRC;
                v       = bus.src_value[w*W +: W];
                r.grant = 4'(1 << w);
                r.arb   = 1'b0;
                if (bus.bcd_mode[w]) begin
                    r.value = cur.value;
                    r.valid = cur.valid;
                    r.busy  = 1'b1;
                    r.ovf   = 1'b0;
                    for (int i = 0; i < 16; i++) q.push_back(r);
                    r.value = dec_show(v);
                    r.ovf   = (v > 9999);
                end else begin
                    r.value = 16'(v);
                    r.ovf   = 1'b0;
                end
                r.valid = 1'b1;
                r.busy  = 1'b0;
                for (int i = 0; i < DWELL; i++) q.push_back(r);
                r.arb = 1'b1;
                q.push_back(r);
                cur     = q.pop_front();
                arb_now = cur.arb;
            end
        end else if (q.size() != 0) begin
            cur     = q.pop_front();
            arb_now = cur.arb;
        end else if (|bus.req) begin
            arb_now = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({bus.grant, bus.disp_value, bus.disp_valid, bus.conv_busy, bus.ovf} !==
                {cur.grant, cur.value, cur.valid, cur.busy, cur.ovf}) begin
                errors++;
                $display("FAIL cycle t=%0t got g=%b v=%h val=%b busy=%b ovf=%b exp g=%b v=%h val=%b busy=%b ovf=%b",
                         $time, bus.grant, bus.disp_value, bus.disp_valid, bus.conv_busy, bus.ovf,
                         cur.grant, cur.value, cur.valid, cur.busy, cur.ovf);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [3:0] sig(input bit use_grant);
        return use_grant ? bus.grant : {3'b0, bus.conv_busy};
    endfunction

    task automatic wait_for(input string nm, input bit use_grant, input logic [3:0] val, input int budget);
        int n;
        n = 0;
        while (sig(use_grant) !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        lit(nm, 32'(sig(use_grant)), 32'(val));
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req       = '0;
        bus.bcd_mode  = '0;
        @(negedge clk);
        lit("reset_state", 32'({bus.grant, bus.disp_valid, bus.conv_busy, bus.ovf}), 32'd0);
        lit("reset_value", 32'(bus.disp_value), 32'd0);
        rst = 1'b0;
    endtask

    logic [3:0] prev;
    logic [3:0] rr_exp [5];
    int         n;

    initial begin
        rst           = 1'b1;
        bus.req       = '0;
        bus.bcd_mode  = '0;
        bus.src_value = '0;
        @(negedge clk);

        // 1: hex source, 1-cycle latency, dwell of 8 then refresh from a new snapshot
        do_reset();
        bus.src_value[0*W +: W] = 16'h1A2F;
        bus.req = 4'b0001;
        wait_for("t1_grant", 1'b1, 4'b0001, 10);
        lit("t1_value", 32'(bus.disp_value), 32'h1A2F);
        lit("t1_valid", 32'(bus.disp_valid), 32'd1);
        bus.src_value[0*W +: W] = 16'h0BEE;
        repeat (8) @(negedge clk);
        lit("t1_arb_hold", 32'(bus.disp_value), 32'h1A2F);
        @(negedge clk);
        lit("t1_refresh", 32'(bus.disp_value), 32'h0BEE);

        // 2: decimal source, 16 busy cycles
        do_reset();
        bus.src_value[1*W +: W] = 16'd1234;
        bus.bcd_mode = 4'b0010;
        bus.req      = 4'b0010;
        wait_for("t2_busy_rise", 1'b0, 4'd1, 10);
        n = 0;
        while (bus.conv_busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        lit("t2_conv_cycles", 32'(n), 32'd16);
        lit("t2_value", 32'(bus.disp_value), 32'h1234);
        lit("t2_grant", 32'(bus.grant), 32'b0010);
        lit("t2_model_value", 32'(cur.value), 32'h1234);

        // 3: all requesting, round-robin order with 9-cycle grant spacing
        do_reset();
        bus.src_value = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        bus.req = 4'b1111;
        rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        prev    = '0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (bus.grant === prev && n < 30) begin
                @(negedge clk);
                n++;
            end
            lit("t3_rr_grant", 32'(bus.grant), 32'(rr_exp[k]));
            if (k > 0) lit("t3_rr_spacing", 32'(n), 32'd9);
            prev = bus.grant;
        end

        // 4: decimal overflow, then the 9999 boundary on the next grant
        do_reset();
        bus.src_value[2*W +: W] = 16'd10000;
        bus.bcd_mode = 4'b0100;
        bus.req      = 4'b0100;
        wait_for("t4_busy_rise", 1'b0, 4'd1, 10);
        wait_for("t4_busy_fall", 1'b0, 4'd0, 30);
        lit("t4_ovf", 32'(bus.ovf), 32'd1);
        lit("t4_pattern", 32'(bus.disp_value), 32'(OVF_PAT));
        bus.src_value[2*W +: W] = 16'd9999;
        wait_for("t4_busy_rise2", 1'b0, 4'd1, 20);
        wait_for("t4_busy_fall2", 1'b0, 4'd0, 30);
        lit("t4_ovf_clear", 32'(bus.ovf), 32'd0);
        lit("t4_value_9999", 32'(bus.disp_value), 32'h9999);

        // 5: reset mid-conversion, pointer back to source 0
        do_reset();
        bus.src_value[2*W +: W] = 16'd77;
        bus.bcd_mode = 4'b0100;
        bus.req      = 4'b0100;
        wait_for("t5_busy_rise", 1'b0, 4'd1, 10);
        repeat (5) @(negedge clk);
        rst          = 1'b1;
        bus.req      = 4'b1111;
        bus.bcd_mode = 4'b0000;
        @(negedge clk);
        lit("t5_outputs_zero",
            32'({bus.grant, bus.disp_valid, bus.conv_busy, bus.ovf}) | 32'(bus.disp_value), 32'd0);
        rst = 1'b0;
        wait_for("t5_first_grant", 1'b1, 4'b0001, 10);

        // 6: request dropped during SHOW -> dwell completes, then idle
        do_reset();
        bus.src_value[0*W +: W] = 16'h0005;
        bus.req = 4'b0001;
        wait_for("t6_grant", 1'b1, 4'b0001, 10);
        repeat (3) @(negedge clk);
        bus.req = 4'b0000;
        repeat (5) @(negedge clk);
        lit("t6_arb_valid", 32'(bus.disp_valid), 32'd1);
        @(negedge clk);
        lit("t6_idle_valid", 32'(bus.disp_valid), 32'd0);
        lit("t6_idle_grant", 32'(bus.grant), 32'd0);
        lit("t6_idle_value", 32'(bus.disp_value), 32'h0005);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
